// File: rtl/vdma_axi4s_to_axi4_core.sv
// Video write DMA: stores an AXI4-Stream frame as a rectangular image in memory,
// one line at a time, split into AXI4 INCR write bursts of at most awlen+1 beats.
module vdma_axi4s_to_axi4_core #(
  parameter int AXI4_ID_WIDTH    = 6,
  parameter int AXI4_ADDR_WIDTH  = 32,
  parameter int AXI4_LEN_WIDTH   = 8,
  parameter int AXI4_QOS_WIDTH   = 4,
  parameter int AXI4S_USER_WIDTH = 1,
  parameter int AXI4S_DATA_WIDTH = 24,
  parameter int STRIDE_WIDTH     = 12,
  parameter int INDEX_WIDTH      = 8,
  parameter int H_WIDTH          = 12,
  parameter int V_WIDTH          = 12
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        ctl_enable,
  input  logic                        ctl_update,
  output logic                        ctl_busy,
  output logic [INDEX_WIDTH-1:0]      ctl_index,
  output logic [2:0]                  dbg_state,
  input  logic [AXI4_ADDR_WIDTH-1:0]  param_addr,
  input  logic [STRIDE_WIDTH-1:0]     param_stride,
  input  logic [H_WIDTH-1:0]          param_width,
  input  logic [V_WIDTH-1:0]          param_height,
  input  logic [AXI4_LEN_WIDTH-1:0]   param_awlen,
  output logic [AXI4_ID_WIDTH-1:0]    m_axi4_awid,
  output logic [AXI4_ADDR_WIDTH-1:0]  m_axi4_awaddr,
  output logic [1:0]                  m_axi4_awburst,
  output logic [3:0]                  m_axi4_awcache,
  output logic [AXI4_LEN_WIDTH-1:0]   m_axi4_awlen,
  output logic                        m_axi4_awlock,
  output logic [2:0]                  m_axi4_awprot,
  output logic [AXI4_QOS_WIDTH-1:0]   m_axi4_awqos,
  output logic [3:0]                  m_axi4_awregion,
  output logic [2:0]                  m_axi4_awsize,
  output logic                        m_axi4_awvalid,
  input  logic                        m_axi4_awready,
  output logic [31:0]                 m_axi4_wdata,
  output logic [3:0]                  m_axi4_wstrb,
  output logic                        m_axi4_wlast,
  output logic                        m_axi4_wvalid,
  input  logic                        m_axi4_wready,
  input  logic [AXI4_ID_WIDTH-1:0]    m_axi4_bid,
  input  logic [1:0]                  m_axi4_bresp,
  input  logic                        m_axi4_bvalid,
  output logic                        m_axi4_bready,
  input  logic [AXI4S_USER_WIDTH-1:0] s_axi4s_tuser,
  input  logic                        s_axi4s_tlast,
  input  logic [AXI4S_DATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                        s_axi4s_tvalid,
  output logic                        s_axi4s_tready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // once raised, a valid (and its payload) is held until that transfer.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    AW   = 3'd2,
    W    = 3'd3,
    FEND = 3'd4
  } state_t;

  localparam int CW    = ((H_WIDTH > AXI4_LEN_WIDTH) ? H_WIDTH : AXI4_LEN_WIDTH) + 2;
  localparam int OUT_W = 16;

  state_t                      state;
  logic [AXI4_ADDR_WIDTH-1:0]  sh_addr;
  logic [STRIDE_WIDTH-1:0]     sh_stride;
  logic [H_WIDTH-1:0]          sh_width;
  logic [V_WIDTH-1:0]          sh_height;
  logic [AXI4_LEN_WIDTH-1:0]   sh_len;
  logic [H_WIDTH-1:0]          x;
  logic [V_WIDTH-1:0]          y;
  logic [AXI4_ADDR_WIDTH-1:0]  line_base;
  logic [OUT_W-1:0]            outstanding;
  logic [AXI4_LEN_WIDTH-1:0]   beat;
  logic [AXI4_ADDR_WIDTH-1:0]  awaddr_q;
  logic [AXI4_LEN_WIDTH-1:0]   awlen_q;
  logic                        awvalid_q;
  logic [INDEX_WIDTH-1:0]      index_q;

  logic                        latch;
  logic                        aw_hs;
  logic                        w_hs;
  logic                        b_hs;
  logic                        last_beat;
  logic [CW-1:0]               x_sum;
  logic                        line_done;
  logic                        frame_done;
  logic [H_WIDTH-1:0]          nx_x;
  logic [AXI4_ADDR_WIDTH-1:0]  nx_base;
  logic [H_WIDTH-1:0]          cx;
  logic [AXI4_ADDR_WIDTH-1:0]  cbase;
  logic [CW-1:0]               len_p1;
  logic [CW-1:0]               remain;
  logic [CW-1:0]               blen;
  logic [AXI4_ADDR_WIDTH-1:0]  next_awaddr;
  logic [AXI4_LEN_WIDTH-1:0]   next_awlen;
  logic                        unused_ok;

  assign unused_ok = ^{m_axi4_bid, m_axi4_bresp, s_axi4s_tlast, s_axi4s_tuser};

  assign m_axi4_awid     = '0;
  assign m_axi4_awburst  = 2'b01;
  assign m_axi4_awcache  = 4'b0011;
  assign m_axi4_awlock   = 1'b0;
  assign m_axi4_awprot   = 3'b000;
  assign m_axi4_awqos    = '0;
  assign m_axi4_awregion = 4'b0000;
  assign m_axi4_awsize   = 3'b010;
  assign m_axi4_awaddr   = awaddr_q;
  assign m_axi4_awlen    = awlen_q;
  assign m_axi4_awvalid  = awvalid_q;
  assign m_axi4_wstrb    = 4'hF;
  assign m_axi4_wdata    = 32'(s_axi4s_tdata);
  assign m_axi4_bready   = 1'b1;
  assign ctl_busy        = (state != IDLE);
  assign ctl_index       = index_q;
  assign dbg_state       = state;

  assign m_axi4_wvalid  = (state == W) && s_axi4s_tvalid;
  assign last_beat      = (beat == awlen_q);
  assign m_axi4_wlast   = (state == W) && last_beat;
  assign s_axi4s_tready = (state == SYNC) ? !(s_axi4s_tvalid && s_axi4s_tuser[0]) :
                          (state == W)    ? m_axi4_wready : 1'b0;

  assign aw_hs = awvalid_q && m_axi4_awready;
  assign w_hs  = (state == W) && s_axi4s_tvalid && m_axi4_wready;
  assign b_hs  = m_axi4_bvalid;
  assign latch = ctl_enable && ((state == IDLE) ||
                 ((state == FEND) && (outstanding == '0) && ctl_update));

  // Position after the burst in flight completes, and the burst that follows it.
  assign x_sum      = CW'(x) + CW'(awlen_q) + CW'(1);
  assign line_done  = (x_sum == CW'(sh_width));
  assign frame_done = line_done && (({1'b0, y} + (V_WIDTH+1)'(1)) == {1'b0, sh_height});
  assign nx_x       = line_done ? '0 : x_sum[H_WIDTH-1:0];
  assign nx_base    = line_done ? line_base + AXI4_ADDR_WIDTH'(sh_stride) : line_base;

  // From SYNC the first burst starts at the frame origin.
  assign cx          = (state == SYNC) ? '0 : nx_x;
  assign cbase       = (state == SYNC) ? sh_addr : nx_base;
  assign len_p1      = CW'(sh_len) + CW'(1);
  assign remain      = CW'(sh_width) - CW'(cx);
  assign blen        = (len_p1 < remain) ? len_p1 : remain;
  assign next_awlen  = AXI4_LEN_WIDTH'(blen - CW'(1));
  assign next_awaddr = cbase + (AXI4_ADDR_WIDTH'(cx) << 2);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sh_addr   <= '0;
      sh_stride <= '0;
      sh_width  <= '0;
      sh_height <= '0;
      sh_len    <= '0;
      index_q   <= '0;
    end else if (latch) begin
      sh_addr   <= param_addr;
      sh_stride <= param_stride;
      sh_width  <= param_width;
      sh_height <= param_height;
      sh_len    <= param_awlen;
      index_q   <= index_q + INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      beat      <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctl_enable) state <= SYNC;
        SYNC: begin
          if (s_axi4s_tvalid && s_axi4s_tuser[0]) begin
            x         <= '0;
            y         <= '0;
            line_base <= sh_addr;
            awaddr_q  <= next_awaddr;
            awlen_q   <= next_awlen;
            awvalid_q <= 1'b1;
            state     <= AW;
          end
        end
        AW: begin
          if (m_axi4_awready) begin
            awvalid_q <= 1'b0;
            beat      <= '0;
            state     <= W;
          end
        end
        W: begin
          if (w_hs) begin
            if (last_beat) begin
              x         <= nx_x;
              line_base <= nx_base;
              if (line_done) y <= y + V_WIDTH'(1);
              if (frame_done) begin
                state <= FEND;
              end else begin
                awaddr_q  <= next_awaddr;
                awlen_q   <= next_awlen;
                awvalid_q <= 1'b1;
                state     <= AW;
              end
            end else begin
              beat <= beat + AXI4_LEN_WIDTH'(1);
            end
          end
        end
        FEND: begin
          if (outstanding == '0) state <= ctl_enable ? SYNC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdma_axi4s_to_axi4_core.sv
// Bench for vdma_axi4s_to_axi4_core: stream driver, memory-slave model with
// random readies and deferred B responses, and AW/W scoreboards.
module tb_vdma_axi4s_to_axi4_core;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        ctl_enable, ctl_update, ctl_busy;
  logic [7:0]  ctl_index;
  logic [2:0]  dbg_state;
  logic [31:0] param_addr;
  logic [11:0] param_stride, param_width, param_height;
  logic [7:0]  param_awlen;
  logic [5:0]  awid, bid;
  logic [31:0] awaddr, wdata;
  logic [1:0]  awburst, bresp;
  logic [3:0]  awcache, awqos, awregion, wstrb;
  logic [7:0]  awlen;
  logic        awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [2:0]  awprot, awsize;
  logic [0:0]  tuser;
  logic        tlast, tvalid, tready;
  logic [23:0] tdata;

  vdma_axi4s_to_axi4_core dut (
    .aclk(aclk), .aresetn(aresetn), .ctl_enable(ctl_enable), .ctl_update(ctl_update),
    .ctl_busy(ctl_busy), .ctl_index(ctl_index), .dbg_state(dbg_state),
    .param_addr(param_addr), .param_stride(param_stride), .param_width(param_width),
    .param_height(param_height), .param_awlen(param_awlen),
    .m_axi4_awid(awid), .m_axi4_awaddr(awaddr), .m_axi4_awburst(awburst),
    .m_axi4_awcache(awcache), .m_axi4_awlen(awlen), .m_axi4_awlock(awlock),
    .m_axi4_awprot(awprot), .m_axi4_awqos(awqos), .m_axi4_awregion(awregion),
    .m_axi4_awsize(awsize), .m_axi4_awvalid(awvalid), .m_axi4_awready(awready),
    .m_axi4_wdata(wdata), .m_axi4_wstrb(wstrb), .m_axi4_wlast(wlast),
    .m_axi4_wvalid(wvalid), .m_axi4_wready(wready),
    .m_axi4_bid(bid), .m_axi4_bresp(bresp), .m_axi4_bvalid(bvalid), .m_axi4_bready(bready),
    .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast), .s_axi4s_tdata(tdata),
    .s_axi4s_tvalid(tvalid), .s_axi4s_tready(tready)
  );

  // ---- clock / watchdog ----
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- scoreboard state ----
  int          vectors = 0;
  int          miscompares = 0;
  int          b_owed = 0;
  int          exp_index = 0;
  logic [39:0] exp_aw_q[$];
  logic [32:0] exp_w_q[$];
  logic [23:0] tx_q[$];
  bit          sb_en = 1, aw_rand = 0, w_rand = 0, b_rand = 0, t_rand = 0, b_hold = 0;

  // ---- memory slave: readies and B responses, driven just after the edge ----
  always begin
    @(posedge aclk);
    #1;
    awready = aw_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    wready  = w_rand  ? ($urandom_range(0, 2) != 0) : 1'b1;
    bvalid  = !b_hold && (b_owed > 0) && (b_rand ? ($urandom_range(0, 3) == 0) : 1'b1);
  end

  // ---- monitor: transfers seen at the falling edge complete on the next rising edge ----
  always @(negedge aclk) begin
    logic [39:0] e_aw;
    logic [32:0] e_w;
    if (aresetn) begin
      if (sb_en && awvalid && awready) begin
        vectors++;
        if (exp_aw_q.size() == 0) begin
          miscompares++;
          $display("FAIL aw_extra: got addr=%h len=%0d, expected no burst", awaddr, awlen);
        end else begin
          e_aw = exp_aw_q.pop_front();
          if ({awaddr, awlen} !== e_aw) begin
            miscompares++;
            $display("FAIL aw_burst: got addr=%h len=%0d, expected addr=%h len=%0d",
                     awaddr, awlen, e_aw[39:8], e_aw[7:0]);
          end
        end
      end
      if (sb_en && wvalid && wready) begin
        vectors++;
        if (exp_w_q.size() == 0) begin
          miscompares++;
          $display("FAIL w_extra: got data=%h last=%b, expected no beat", wdata, wlast);
        end else begin
          e_w = exp_w_q.pop_front();
          if ({wlast, wdata} !== e_w) begin
            miscompares++;
            $display("FAIL w_beat: got data=%h last=%b, expected data=%h last=%b",
                     wdata, wlast, e_w[31:0], e_w[32]);
          end
        end
      end
      if (wvalid && wready && wlast) b_owed++;
      if (bvalid && bready) b_owed--;
    end
  end

  // ---- driver tasks ----
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic set_params(input logic [31:0] a, input int stride, input int w,
                            input int h, input int len_p1);
    param_addr   = a;
    param_stride = 12'(stride);
    param_width  = 12'(w);
    param_height = 12'(h);
    param_awlen  = 8'(len_p1 - 1);
  endtask

  // Independent model of the burst split: push expected AW/W and the pixels to send.
  task automatic expect_frame(input logic [31:0] base, input int stride, input int w,
                              input int h, input int len_p1);
    int bl;
    logic [23:0] d;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx += bl) begin
        bl = (len_p1 < w - xx) ? len_p1 : w - xx;
        exp_aw_q.push_back({32'(base + 32'(yy * stride) + 32'(xx * 4)), 8'(bl - 1)});
        for (int b = 0; b < bl; b++) begin
          d = 24'($urandom());
          tx_q.push_back(d);
          exp_w_q.push_back({(b == bl - 1), 8'h00, d});
        end
      end
    end
  endtask

  task automatic send_beat(input logic [23:0] d, input logic u, output bit ok);
    tvalid = 1'b1;
    tdata  = d;
    tuser  = u;
    ok     = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
    if (t_rand) tick($urandom_range(0, 2));
  endtask

  // post: 1 drop enable, 2 move address + request update, 3 drop enable + update
  task automatic send_frame(input int junk, input int npix, input int post);
    bit ok;
    for (int j = 0; j < junk; j++) begin
      send_beat(24'($urandom()), 1'b0, ok);
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL junk_accept: got tready=0 for 2000 cycles, expected 1");
        return;
      end
    end
    for (int p = 0; p < npix; p++) begin
      send_beat(tx_q.pop_front(), (p == 0), ok);
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL beat_accept: got tready=0 for 2000 cycles at pixel %0d, expected 1", p);
        tx_q.delete();
        return;
      end
      if (p == 0) begin
        case (post)
          1: ctl_enable = 1'b0;
          2: begin param_addr = 32'h2000; ctl_update = 1'b1; end
          3: begin ctl_enable = 1'b0; ctl_update = 1'b0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge aclk);
      if (!ctl_busy) begin
        idle = 1'b1;
        break;
      end
    end
    vectors++;
    if (!idle) begin
      miscompares++;
      $display("FAIL %s_idle: got ctl_busy=1 after 5000 cycles, expected 0", name);
    end
    vectors++;
    if (exp_aw_q.size() != 0 || exp_w_q.size() != 0 || b_owed != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d AW / %0d W left, %0d B owed, expected 0/0/0",
               name, exp_aw_q.size(), exp_w_q.size(), b_owed);
    end
    vectors++;
    if (ctl_index !== 8'(exp_index)) begin
      miscompares++;
      $display("FAIL %s_index: got %0d, expected %0d", name, ctl_index, exp_index);
    end
    @(posedge aclk);
    #1;
  endtask

  // ---- tests ----
  task automatic test_reset();
    aresetn = 1'b0;
    tvalid  = 1'b1;
    tick(3);
    vectors++; if (awvalid !== 1'b0) begin miscompares++; $display("FAIL rst_awvalid: got %b, expected 0", awvalid); end
    vectors++; if (wvalid !== 1'b0) begin miscompares++; $display("FAIL rst_wvalid: got %b, expected 0", wvalid); end
    vectors++; if (tready !== 1'b0) begin miscompares++; $display("FAIL rst_tready: got %b, expected 0", tready); end
    vectors++; if (wlast !== 1'b0) begin miscompares++; $display("FAIL rst_wlast: got %b, expected 0", wlast); end
    vectors++; if (ctl_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, expected 0", ctl_busy); end
    vectors++; if (ctl_index !== 8'd0) begin miscompares++; $display("FAIL rst_index: got %0d, expected 0", ctl_index); end
    vectors++; if (awaddr !== 32'd0) begin miscompares++; $display("FAIL rst_awaddr: got %h, expected 0", awaddr); end
    vectors++; if (awlen !== 8'd0) begin miscompares++; $display("FAIL rst_awlen: got %0d, expected 0", awlen); end
    vectors++;
    if ({awburst, awcache, awsize, wstrb, bready} !== {2'b01, 4'b0011, 3'b010, 4'hF, 1'b1}) begin
      miscompares++;
      $display("FAIL const_fields: got burst=%b cache=%b size=%b strb=%h bready=%b, expected 01 0011 010 f 1",
               awburst, awcache, awsize, wstrb, bready);
    end
    tvalid = 1'b0;
    aresetn = 1'b1;
    tick(2);
  endtask

  task automatic test_addressing();
    set_params(32'h1000, 'h100, 4, 2, 2);
    expect_frame(32'h1000, 'h100, 4, 2, 2);
    b_hold = 1'b1;
    ctl_enable = 1'b1;
    exp_index++;
    tick(1);
    vectors++;
    if (dbg_state !== 3'd1) begin
      miscompares++;
      $display("FAIL enable_to_sync: got state=%0d, expected 1", dbg_state);
    end
    send_frame(0, 8, 1);
    tick(10);
    vectors++;
    if (ctl_busy !== 1'b1 || dbg_state !== 3'd4) begin
      miscompares++;
      $display("FAIL fend_wait_b: got busy=%b state=%0d, expected busy=1 state=4", ctl_busy, dbg_state);
    end
    b_hold = 1'b0;
    wait_idle("addressing");
  endtask

  task automatic test_short_burst();
    set_params(32'h3000, 'h40, 5, 2, 4);
    expect_frame(32'h3000, 'h40, 5, 2, 4);
    ctl_enable = 1'b1;
    exp_index++;
    send_frame(0, 10, 1);
    wait_idle("short_burst");
  endtask

  task automatic test_frame_sync();
    set_params(32'h4000, 'h10, 2, 1, 2);
    expect_frame(32'h4000, 'h10, 2, 1, 2);
    tx_q[0] = 24'hABCDEF;
    exp_w_q[0] = {1'b0, 32'h00ABCDEF};
    ctl_enable = 1'b1;
    exp_index++;
    send_frame(3, 2, 1);
    wait_idle("frame_sync");
  endtask

  task automatic test_back_to_back();
    aw_rand = 1; w_rand = 1; b_rand = 1; t_rand = 1;
    set_params(32'h8000, 'h20, 7, 3, 3);
    expect_frame(32'h8000, 'h20, 7, 3, 3);
    expect_frame(32'h8000, 'h20, 7, 3, 3);
    ctl_enable = 1'b1;
    exp_index++;
    send_frame(0, 21, 0);
    send_frame(2, 21, 1);
    wait_idle("backpressure");
    aw_rand = 0; w_rand = 0; b_rand = 0; t_rand = 0;
  endtask

  task automatic test_update();
    set_params(32'h1000, 'h100, 4, 2, 4);
    expect_frame(32'h1000, 'h100, 4, 2, 4);
    expect_frame(32'h2000, 'h100, 4, 2, 4);
    ctl_enable = 1'b1;
    exp_index += 2;
    send_frame(0, 8, 2);
    send_frame(0, 8, 3);
    wait_idle("update");
  endtask

  task automatic test_reset_during_w();
    sb_en = 1'b0;
    set_params(32'h5000, 'h40, 8, 1, 8);
    ctl_enable = 1'b1;
    tvalid = 1'b1;
    tuser  = 1'b1;
    tdata  = 24'h123456;
    tick(6);
    vectors++;
    if (dbg_state !== 3'd3) begin
      miscompares++;
      $display("FAIL pre_reset_state: got %0d, expected 3", dbg_state);
    end
    aresetn = 1'b0;
    #1;
    vectors++; if (awvalid !== 1'b0) begin miscompares++; $display("FAIL rstw_awvalid: got %b, expected 0", awvalid); end
    vectors++; if (tready !== 1'b0) begin miscompares++; $display("FAIL rstw_tready: got %b, expected 0", tready); end
    vectors++; if (ctl_busy !== 1'b0) begin miscompares++; $display("FAIL rstw_busy: got %b, expected 0", ctl_busy); end
    vectors++; if (ctl_index !== 8'd0) begin miscompares++; $display("FAIL rstw_index: got %0d, expected 0", ctl_index); end
    tvalid = 1'b0;
    tuser  = 1'b0;
    ctl_enable = 1'b0;
    exp_aw_q.delete();
    exp_w_q.delete();
    tx_q.delete();
    b_owed = 0;
    tick(2);
    aresetn = 1'b1;
    tick(2);
    sb_en = 1'b1;
  endtask

  // ---- sequence ----
  initial begin
    aresetn = 1'b0;
    ctl_enable = 1'b0;
    ctl_update = 1'b0;
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    awready = 1'b1;
    wready  = 1'b1;
    bvalid  = 1'b0;
    bid     = '0;
    bresp   = 2'b00;
    set_params(32'h0, 0, 1, 1, 1);
    tick(1);
    test_reset();
    test_addressing();
    test_short_burst();
    test_frame_sync();
    test_back_to_back();
    test_update();
    test_reset_during_w();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
